// File: rtl/layer_priority_mux.sv
// N-layer priority pixel mux: per-layer enable/blink/colour-key, 2-stage pipeline,
// and per-frame layer-overlap reporting for game logic.

module layer_lane #(
  parameter int                 RGB_W           = 8,
  parameter logic [RGB_W-1:0]   TRANSPARENT_RGB = 8'hFF
) (
  input  logic             i_req,
  input  logic             i_en,
  input  logic             i_blink,
  input  logic             i_phase,
  input  logic [RGB_W-1:0] i_rgb,
  output logic             o_eff
);
  assign o_eff = i_req & i_en & ~(i_blink & i_phase) & (i_rgb != TRANSPARENT_RGB);
endmodule

module layer_priority_mux #(
  parameter int                 NUM_LAYERS      = 8,
  parameter int                 RGB_W           = 8,
  parameter logic [RGB_W-1:0]   TRANSPARENT_RGB = 8'hFF,
  parameter int                 BLINK_FRAMES    = 16
) (
  input  logic                                clk,
  input  logic                                resetN,
  input  logic                                startOfFrame,
  input  logic                                pixelValid_in,
  input  logic [NUM_LAYERS-1:0]               drawReq,
  input  logic [NUM_LAYERS*RGB_W-1:0]         layerRGB,
  input  logic [RGB_W-1:0]                    backGroundRGB,
  input  logic                                cfgWr,
  input  logic [NUM_LAYERS-1:0]               cfgEnable,
  input  logic [NUM_LAYERS-1:0]               cfgBlink,
  output logic [RGB_W-1:0]                    RGBOut,
  output logic                                pixelValid_out,
  output logic [$clog2(NUM_LAYERS+1)-1:0]     topLayer,
  output logic [NUM_LAYERS-1:0]               collisionMask,
  output logic                                collisionPulse
);
  localparam int IDX_W  = $clog2(NUM_LAYERS+1);
  localparam int CNT_W  = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam int STAGES = 2;

  logic [NUM_LAYERS-1:0][RGB_W-1:0] w_rgb;
  logic [NUM_LAYERS-1:0]            w_eff;
  logic [IDX_W-1:0]                 w_win_idx;
  logic [RGB_W-1:0]                 w_win_rgb;
  logic                             w_multi;
  logic [NUM_LAYERS-1:0]            w_s1_ovl;
  logic [NUM_LAYERS-1:0]            w_frame_ovl;

  logic [NUM_LAYERS-1:0]            r_enable, r_blink;
  logic [CNT_W-1:0]                 r_frame_cnt;
  logic                             r_blink_phase;
  logic [STAGES:1]                  r_vld_pipe;
  logic [IDX_W-1:0]                 r_s1_idx;
  logic [RGB_W-1:0]                 r_s1_rgb;
  logic                             r_s1_multi;
  logic [NUM_LAYERS-1:0]            r_s1_eff;
  logic [RGB_W-1:0]                 r_rgb_out;
  logic [IDX_W-1:0]                 r_top;
  logic [NUM_LAYERS-1:0]            r_acc, r_col_mask;
  logic                             r_col_pulse;

  assign w_rgb = layerRGB;

  for (genvar g = 0; g < NUM_LAYERS; g++) begin : g_lane
    layer_lane #(.RGB_W(RGB_W), .TRANSPARENT_RGB(TRANSPARENT_RGB)) u_lane (
      .i_req   (drawReq[g]),
      .i_en    (r_enable[g]),
      .i_blink (r_blink[g]),
      .i_phase (r_blink_phase),
      .i_rgb   (w_rgb[g]),
      .o_eff   (w_eff[g])
    );
  end

  // Scan high to low so the lowest visible index ends up winning.
  always_comb begin
    w_win_idx = IDX_W'(NUM_LAYERS);
    w_win_rgb = backGroundRGB;
    for (int i = NUM_LAYERS-1; i >= 0; i--) begin
      if (w_eff[i]) begin
        w_win_idx = IDX_W'(i);
        w_win_rgb = w_rgb[i];
      end
    end
  end

  // Clearing the lowest set bit leaves something only when two or more layers are visible.
  assign w_multi     = pixelValid_in & (|(w_eff & (w_eff - NUM_LAYERS'(1))));
  assign w_s1_ovl    = r_s1_multi ? r_s1_eff : '0;
  assign w_frame_ovl = r_acc | w_s1_ovl;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_enable <= '1;
      r_blink  <= '0;
    end else if (cfgWr) begin
      r_enable <= cfgEnable;
      r_blink  <= cfgBlink;
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_frame_cnt   <= '0;
      r_blink_phase <= 1'b0;
    end else if (startOfFrame) begin
      if (r_frame_cnt == CNT_W'(BLINK_FRAMES-1)) begin
        r_frame_cnt   <= '0;
        r_blink_phase <= ~r_blink_phase;
      end else begin
        r_frame_cnt   <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_vld_pipe <= '0;
      r_s1_idx   <= IDX_W'(NUM_LAYERS);
      r_s1_rgb   <= '0;
      r_s1_multi <= 1'b0;
      r_s1_eff   <= '0;
      r_rgb_out  <= '0;
      r_top      <= IDX_W'(NUM_LAYERS);
    end else begin
      r_vld_pipe <= {r_vld_pipe[STAGES-1:1], pixelValid_in};
      r_s1_idx   <= w_win_idx;
      r_s1_rgb   <= w_win_rgb;
      r_s1_multi <= w_multi;
      r_s1_eff   <= w_eff;
      r_rgb_out  <= r_vld_pipe[1] ? r_s1_rgb : '0;
      r_top      <= r_s1_idx;
    end
  end

  // The pixel sitting in stage 1 at startOfFrame still belongs to the closing frame.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_acc       <= '0;
      r_col_mask  <= '0;
      r_col_pulse <= 1'b0;
    end else if (startOfFrame) begin
      r_col_mask  <= w_frame_ovl;
      r_acc       <= '0;
      r_col_pulse <= |w_frame_ovl;
    end else begin
      r_acc       <= w_frame_ovl;
      r_col_pulse <= 1'b0;
    end
  end

  assign RGBOut         = r_rgb_out;
  assign pixelValid_out = r_vld_pipe[STAGES];
  assign topLayer       = r_top;
  assign collisionMask  = r_col_mask;
  assign collisionPulse = r_col_pulse;
endmodule

// File: tb/tb_layer_priority_mux.sv
// Bench for layer_priority_mux: directed vector table, frame-level corner sequences,
// and randomized traffic against a per-pixel / per-frame reference model.
module tb_layer_priority_mux;
  localparam int NL = 8;
  localparam int W  = 8;
  localparam int BF = 2;
  localparam int IW = $clog2(NL+1);

  logic            clk = 1'b0, resetN = 1'b1;
  logic            startOfFrame = 1'b0, pixelValid_in = 1'b0, cfgWr = 1'b0;
  logic [NL-1:0]   drawReq = '0, cfgEnable = '1, cfgBlink = '0;
  logic [NL*W-1:0] layerRGB = '0;
  logic [W-1:0]    backGroundRGB = 8'h24;
  logic [W-1:0]    RGBOut;
  logic            pixelValid_out;
  logic [IW-1:0]   topLayer;
  logic [NL-1:0]   collisionMask;
  logic            collisionPulse;

  layer_priority_mux #(.NUM_LAYERS(NL), .RGB_W(W), .TRANSPARENT_RGB(8'hFF), .BLINK_FRAMES(BF)) dut (
    .clk(clk), .resetN(resetN), .startOfFrame(startOfFrame), .pixelValid_in(pixelValid_in),
    .drawReq(drawReq), .layerRGB(layerRGB), .backGroundRGB(backGroundRGB), .cfgWr(cfgWr),
    .cfgEnable(cfgEnable), .cfgBlink(cfgBlink), .RGBOut(RGBOut), .pixelValid_out(pixelValid_out),
    .topLayer(topLayer), .collisionMask(collisionMask), .collisionPulse(collisionPulse)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_err = 0;

  // Reference model state: config, frames seen, per-frame overlap, and the pixel in flight.
  logic [NL-1:0] m_en, m_blink, m_acc, e_mask;
  logic          e_pulse, p_vld, e_vld;
  int            m_sofs;
  logic [W-1:0]  p_rgb, e_rgb;
  logic [IW-1:0] p_top, e_top;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_en = '1; m_blink = '0; m_acc = '0; e_mask = '0; e_pulse = 1'b0; m_sofs = 0;
    p_rgb = '0; p_top = IW'(NL); p_vld = 1'b0;
    e_rgb = '0; e_top = IW'(NL); e_vld = 1'b0;
  endtask

  task automatic set_idle();
    startOfFrame = 1'b0; pixelValid_in = 1'b0; drawReq = '0; cfgWr = 1'b0;
  endtask

  task automatic set_layer(input int i, input logic [W-1:0] c);
    layerRGB[i*W +: W] = c;
  endtask

  // Apply current inputs for one clock and check every output against the model.
  task automatic step();
    logic [NL-1:0] eff;
    logic [W-1:0]  lr, win_rgb;
    logic          phase, multi;
    int            win;
    phase   = ((m_sofs / BF) % 2) == 1;
    win     = NL;
    win_rgb = backGroundRGB;
    for (int i = 0; i < NL; i++) begin
      lr     = layerRGB[i*W +: W];
      eff[i] = drawReq[i] && m_en[i] && !(m_blink[i] && phase) && (lr != 8'hFF);
    end
    for (int i = NL-1; i >= 0; i--)
      if (eff[i]) begin win = i; win_rgb = layerRGB[i*W +: W]; end
    multi = pixelValid_in && ($countones(eff) >= 2);
    e_rgb = p_vld ? p_rgb : '0; e_top = p_top; e_vld = p_vld;
    p_vld = pixelValid_in; p_top = IW'(win); p_rgb = win_rgb;
    if (startOfFrame) begin
      e_mask  = m_acc;
      e_pulse = (m_acc != '0);
      m_acc   = multi ? eff : '0;
      m_sofs++;
    end else begin
      e_pulse = 1'b0;
      if (multi) m_acc = m_acc | eff;
    end
    if (cfgWr) begin m_en = cfgEnable; m_blink = cfgBlink; end
    @(posedge clk); #1;
    chk("RGBOut", RGBOut, e_rgb);
    chk("topLayer", topLayer, e_top);
    chk("pixelValid_out", pixelValid_out, e_vld);
    chk("collisionMask", collisionMask, e_mask);
    chk("collisionPulse", collisionPulse, e_pulse);
  endtask

  // Asserts reset mid-cycle and checks outputs clear without waiting for a clock.
  task automatic do_reset();
    #2; resetN = 1'b0; #1;
    chk("rst_RGBOut", RGBOut, 0);
    chk("rst_pixelValid_out", pixelValid_out, 0);
    chk("rst_topLayer", topLayer, NL);
    chk("rst_collisionMask", collisionMask, 0);
    chk("rst_collisionPulse", collisionPulse, 0);
    set_idle();
    @(posedge clk); #1;
    resetN = 1'b1;
    model_reset();
  endtask

  typedef struct {
    logic            vld;
    logic [NL-1:0]   req;
    logic [NL*W-1:0] rgb;
    logic            cfg_wr;
    logic [NL-1:0]   en;
    logic [W-1:0]    exp_rgb;
    logic [IW-1:0]   exp_top;
  } vec_t;

  vec_t tbl[9];
  logic [5:0] vis_pat;

  initial begin
    tbl[0] = '{1'b1, 8'h08, 64'h0000_0000_1C00_0000, 1'b0, 8'hFF, 8'h1C, 4'd3};
    tbl[1] = '{1'b1, 8'h12, 64'h0000_0003_0000_E000, 1'b0, 8'hFF, 8'hE0, 4'd1};
    tbl[2] = '{1'b1, 8'h05, 64'h0000_0000_0055_00FF, 1'b0, 8'hFF, 8'h55, 4'd2};
    tbl[3] = '{1'b0, 8'h00, 64'h0,                   1'b1, 8'hFE, 8'h00, 4'd8};
    tbl[4] = '{1'b1, 8'h01, 64'h0000_0000_0000_0012, 1'b0, 8'hFE, 8'h24, 4'd8};
    tbl[5] = '{1'b1, 8'h01, 64'h0000_0000_0000_0012, 1'b1, 8'hFF, 8'h24, 4'd8};
    tbl[6] = '{1'b1, 8'h01, 64'h0000_0000_0000_0012, 1'b0, 8'hFF, 8'h12, 4'd0};
    tbl[7] = '{1'b0, 8'h04, 64'h0000_0000_0077_0000, 1'b0, 8'hFF, 8'h00, 4'd2};
    tbl[8] = '{1'b1, 8'h80, 64'hFE00_0000_0000_0000, 1'b0, 8'hFF, 8'hFE, 4'd7};

    model_reset();
    do_reset();

    for (int i = 0; i < 9; i++) begin
      pixelValid_in = tbl[i].vld; drawReq = tbl[i].req; layerRGB = tbl[i].rgb;
      cfgWr = tbl[i].cfg_wr; cfgEnable = tbl[i].en; cfgBlink = '0;
      step();
      set_idle();
      step();
      chk("tbl_rgb", RGBOut, tbl[i].exp_rgb);
      chk("tbl_top", topLayer, tbl[i].exp_top);
    end

    // Two overlapping layers report at the next frame boundary; pulse lasts one cycle.
    do_reset();
    layerRGB = '0; set_layer(1, 8'hE0); set_layer(4, 8'h03);
    drawReq = 8'h12; pixelValid_in = 1'b1; step();
    set_idle(); step();
    chk("ovl_rgb", RGBOut, 8'hE0);
    startOfFrame = 1'b1; step();
    chk("ovl_mask", collisionMask, 8'h12);
    chk("ovl_pulse", collisionPulse, 1);
    set_idle(); step();
    chk("ovl_pulse_clr", collisionPulse, 0);
    chk("ovl_mask_hold", collisionMask, 8'h12);

    // A transparent top layer leaves a single visible layer: no overlap.
    layerRGB = '0; set_layer(0, 8'hFF); set_layer(2, 8'h55);
    drawReq = 8'h05; pixelValid_in = 1'b1; step();
    set_idle(); step();
    chk("key_rgb", RGBOut, 8'h55);
    chk("key_top", topLayer, 2);
    startOfFrame = 1'b1; step();
    chk("key_mask", collisionMask, 0);
    chk("key_pulse", collisionPulse, 0);

    // Blink with two-frame half-period: frames 0-1 visible, 2-3 hidden, 4-5 visible.
    do_reset();
    vis_pat = 6'b110011;
    cfgWr = 1'b1; cfgEnable = '1; cfgBlink = 8'h20; step();
    layerRGB = '0; set_layer(5, 8'h1C);
    for (int n = 0; n < 6; n++) begin
      set_idle();
      if (n > 0) begin startOfFrame = 1'b1; step(); set_idle(); end
      drawReq = 8'h20; pixelValid_in = 1'b1; step();
      set_idle(); step();
      chk($sformatf("blink_f%0d", n), RGBOut, vis_pat[n] ? 8'h1C : 8'h24);
    end

    // Reset mid-frame after overlaps: nothing reported, outputs blank until pixels return.
    do_reset();
    layerRGB = '0; set_layer(0, 8'h11); set_layer(1, 8'h22);
    drawReq = 8'h03; pixelValid_in = 1'b1; step(); step();
    do_reset();
    startOfFrame = 1'b1; step();
    chk("rstf_mask", collisionMask, 0);
    chk("rstf_pulse", collisionPulse, 0);
    set_idle(); layerRGB = '0; set_layer(3, 8'h1C);
    drawReq = 8'h08; pixelValid_in = 1'b1; step();
    chk("rstf_vld_early", pixelValid_out, 0);
    chk("rstf_rgb_early", RGBOut, 0);
    step();
    chk("rstf_vld", pixelValid_out, 1);
    chk("rstf_rgb", RGBOut, 8'h1C);

    // Randomized traffic: frequent frame starts, colour keys, config writes.
    for (int k = 0; k < 3000; k++) begin
      if (k == 1500) do_reset();
      startOfFrame  = ($urandom_range(0, 15) == 0);
      pixelValid_in = ($urandom_range(0, 3) != 0);
      drawReq       = NL'($urandom) & NL'($urandom);
      for (int i = 0; i < NL; i++)
        layerRGB[i*W +: W] = ($urandom_range(0, 3) == 0) ? 8'hFF : W'($urandom);
      backGroundRGB = W'($urandom);
      cfgWr         = ($urandom_range(0, 31) == 0);
      cfgEnable     = NL'($urandom);
      cfgBlink      = NL'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
